// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch queue between a variable-latency instruction memory and the fetch stage.
// Issues sequential word fetches, buffers DEPTH {PC, instr} pairs, and flushes on decode redirects.
module instr_prefetch_buffer #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       INSTR_WIDTH   = 32,
  parameter int                       DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_PCSrcD,
  input  logic [ADDRESS_WIDTH-1:0] i_PCBranchD,
  input  logic                     i_StallF,
  output logic                     o_InstrValidF,
  output logic [INSTR_WIDTH-1:0]   o_InstrF,
  output logic [ADDRESS_WIDTH-1:0] o_PCF,
  output logic [ADDRESS_WIDTH-1:0] o_PCPlus4F,
  output logic                     o_MemReq,
  output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
  input  logic                     i_MemAck,
  input  logic [INSTR_WIDTH-1:0]   i_MemRData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] WordStep = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t                   stateQ;
  logic                     memReqQ;
  logic [ADDRESS_WIDTH-1:0] memAddrQ;
  logic [ADDRESS_WIDTH-1:0] fetchPcQ;
  logic [CW-1:0]            countQ;
  logic [CW-1:0]            countD;
  logic [PW-1:0]            rdPtrQ;
  logic [PW-1:0]            wrPtrQ;

  logic [ADDRESS_WIDTH-1:0] pcMemQ    [DEPTH];
  logic [INSTR_WIDTH-1:0]   instrMemQ [DEPTH];

  logic ack;
  logic valid;
  logic push;
  logic pop;
  logic hasRoom;

  assign ack   = memReqQ & i_MemAck;
  assign valid = (countQ != '0);
  assign pop   = valid & ~i_StallF & ~i_PCSrcD;
  assign push  = (stateQ == REQ) & ack & ~i_PCSrcD;

  // Occupancy after this edge; a same-cycle pop frees the slot a new request may reserve.
  always_comb begin
    countD = countQ;
    if (i_PCSrcD) begin
      countD = '0;
    end else begin
      countD = countQ + CW'(push) - CW'(pop);
    end
  end

  assign hasRoom = (countD < DepthC);

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      stateQ   <= IDLE;
      memReqQ  <= 1'b0;
      memAddrQ <= RESET_PC;
      fetchPcQ <= RESET_PC;
      countQ   <= '0;
      rdPtrQ   <= '0;
      wrPtrQ   <= '0;
    end else begin
      countQ <= countD;
      if (i_PCSrcD) begin
        rdPtrQ <= '0;
        wrPtrQ <= '0;
      end else begin
        if (push) wrPtrQ <= wrPtrQ + 1'b1;
        if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
      end

      case (stateQ)
        IDLE: begin
          if (i_PCSrcD) begin
            fetchPcQ <= i_PCBranchD;
            memReqQ  <= 1'b1;
            memAddrQ <= i_PCBranchD;
            stateQ   <= REQ;
          end else if (hasRoom) begin
            memReqQ  <= 1'b1;
            memAddrQ <= fetchPcQ;
            stateQ   <= REQ;
          end
        end

        REQ: begin
          if (i_PCSrcD) begin
            fetchPcQ <= i_PCBranchD;
            if (ack) begin
              memAddrQ <= i_PCBranchD;
            end else begin
              // The old request must still complete before the target can be issued.
              stateQ <= DROP;
            end
          end else if (ack) begin
            fetchPcQ <= memAddrQ + WordStep;
            if (hasRoom) begin
              memAddrQ <= memAddrQ + WordStep;
            end else begin
              memReqQ <= 1'b0;
              stateQ  <= IDLE;
            end
          end
        end

        DROP: begin
          if (i_PCSrcD) begin
            fetchPcQ <= i_PCBranchD;
            if (ack) begin
              memAddrQ <= i_PCBranchD;
              stateQ   <= REQ;
            end
          end else if (ack) begin
            memAddrQ <= fetchPcQ;
            stateQ   <= REQ;
          end
        end

        default: begin
          memReqQ <= 1'b0;
          stateQ  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (push) begin
      pcMemQ[wrPtrQ]    <= memAddrQ;
      instrMemQ[wrPtrQ] <= i_MemRData;
    end
  end

  assign o_InstrValidF = valid;
  assign o_PCF         = valid ? pcMemQ[rdPtrQ] : '0;
  assign o_InstrF      = valid ? instrMemQ[rdPtrQ] : '0;
  assign o_PCPlus4F    = o_PCF + WordStep;
  assign o_MemReq      = memReqQ;
  assign o_MemAddr     = memAddrQ;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: one instance at RESET_PC=0 with a configurable-latency
// memory, a second at RESET_PC=FFFF_FFF8 with a zero-wait memory for address wrap-around.
module tb_instr_prefetch_buffer;

  logic        clock = 1'b0;
  logic        rstN;
  logic        pcSrc;
  logic [31:0] pcBranch;
  logic        stall;
  logic        validF;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] pcPlus4F;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memRData;

  logic        pcSrc2;
  logic [31:0] pcBranch2;
  logic        stall2;
  logic        validF2;
  logic [31:0] instrF2;
  logic [31:0] pcF2;
  logic [31:0] pcPlus4F2;
  logic        memReq2;
  logic [31:0] memAddr2;
  logic        memAck2;
  logic [31:0] memRData2;

  logic memAuto;
  logic manualAck;
  int   latency;
  int   waitCnt;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clock = ~clock;

  instr_prefetch_buffer dut (
    .i_CLK        (clock),
    .i_RST        (rstN),
    .i_PCSrcD     (pcSrc),
    .i_PCBranchD  (pcBranch),
    .i_StallF     (stall),
    .o_InstrValidF(validF),
    .o_InstrF     (instrF),
    .o_PCF        (pcF),
    .o_PCPlus4F   (pcPlus4F),
    .o_MemReq     (memReq),
    .o_MemAddr    (memAddr),
    .i_MemAck     (memAck),
    .i_MemRData   (memRData)
  );

  instr_prefetch_buffer #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .i_CLK        (clock),
    .i_RST        (rstN),
    .i_PCSrcD     (pcSrc2),
    .i_PCBranchD  (pcBranch2),
    .i_StallF     (stall2),
    .o_InstrValidF(validF2),
    .o_InstrF     (instrF2),
    .o_PCF        (pcF2),
    .o_PCPlus4F   (pcPlus4F2),
    .o_MemReq     (memReq2),
    .o_MemAddr    (memAddr2),
    .i_MemAck     (memAck2),
    .i_MemRData   (memRData2)
  );

  // Memory acks once a request has been held for 'latency' cycles; data is a scramble of the address.
  assign memAck    = memAuto ? (memReq && (waitCnt == latency)) : manualAck;
  assign memRData  = memAddr ^ 32'hC0DE_0000;
  assign memAck2   = memReq2;
  assign memRData2 = memAddr2 ^ 32'hC0DE_0000;

  always @(posedge clock or negedge rstN) begin
    if (!rstN) waitCnt <= 0;
    else if (memReq && memAck) waitCnt <= 0;
    else if (memReq) waitCnt <= waitCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic src, input logic [31:0] br, input logic stl);
    pcSrc    = src;
    pcBranch = br;
    stall    = stl;
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut();
    rstN   = 1'b0;
    pcSrc  = 1'b0;
    stall  = 1'b0;
    stall2 = 1'b1;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    rstN      = 1'b0;
    pcSrc     = 1'b0;
    pcBranch  = '0;
    stall     = 1'b0;
    pcSrc2    = 1'b0;
    pcBranch2 = '0;
    stall2    = 1'b1;
    memAuto   = 1'b1;
    manualAck = 1'b0;
    latency   = 0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    checkOutput("rst_valid", 32'(validF), 32'd0);
    checkOutput("rst_req", 32'(memReq), 32'd0);
    checkOutput("rst_addr", memAddr, 32'h0);
    checkOutput("rst_pc", pcF, 32'h0);
    checkOutput("rst_instr", instrF, 32'h0);
    checkOutput("rst_wrap_addr", memAddr2, 32'hFFFF_FFF8);
    rstN = 1'b1;

    // Zero-wait streaming
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s1_req", 32'(memReq), 32'd1);
    checkOutput("s1_addr0", memAddr, 32'h0);
    checkOutput("s1_valid_early", 32'(validF), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s1_valid", 32'(validF), 32'd1);
    checkOutput("s1_pc0", pcF, 32'h0);
    checkOutput("s1_instr0", instrF, 32'hC0DE_0000);
    checkOutput("s1_plus4", pcPlus4F, 32'h4);
    checkOutput("s1_addr4", memAddr, 32'h4);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("s1_pc", pcF, 32'(i * 4));
      checkOutput("s1_instr", instrF, 32'(i * 4) ^ 32'hC0DE_0000);
      checkOutput("s1_addr", memAddr, 32'((i + 1) * 4));
    end

    // Stall fills the queue, then drains in order
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s2_req4", 32'(memReq), 32'd1);
    checkOutput("s2_addr4", memAddr, 32'hC);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s2_full_req", 32'(memReq), 32'd0);
    checkOutput("s2_full_pc", pcF, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("s2_hold_req", 32'(memReq), 32'd0);
    checkOutput("s2_hold_pc", pcF, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s2_pop_pc4", pcF, 32'h4);
    checkOutput("s2_resume_req", 32'(memReq), 32'd1);
    checkOutput("s2_resume_addr", memAddr, 32'h10);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s2_pop_pc8", pcF, 32'h8);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s2_pop_pcC", pcF, 32'hC);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s2_pop_pc10", pcF, 32'h10);

    // Redirect while a slow request is outstanding
    latency = 3;
    resetDut();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s3_req", 32'(memReq), 32'd1);
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("s3_drop_req", 32'(memReq), 32'd1);
    checkOutput("s3_drop_addr", memAddr, 32'h0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("s3_hold_addr", memAddr, 32'h0);
      checkOutput("s3_hold_valid", 32'(validF), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s3_target_addr", memAddr, 32'h100);
    checkOutput("s3_discard_valid", 32'(validF), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("s3_wait_valid", 32'(validF), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s3_valid", 32'(validF), 32'd1);
    checkOutput("s3_pc", pcF, 32'h100);
    checkOutput("s3_instr", instrF, 32'hC0DE_0100);

    // Redirect coinciding with ack and pop
    memAuto   = 1'b0;
    manualAck = 1'b1;
    applyStimulus(1'b1, 32'h400, 1'b0);
    checkOutput("s4_flush_valid", 32'(validF), 32'd0);
    checkOutput("s4_addr", memAddr, 32'h400);
    checkOutput("s4_req", 32'(memReq), 32'd1);
    manualAck = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s4_empty", 32'(validF), 32'd0);
    manualAck = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s4_pc", pcF, 32'h400);
    checkOutput("s4_instr", instrF, 32'hC0DE_0400);
    manualAck = 1'b0;
    memAuto   = 1'b1;

    // Two redirects while dropping
    resetDut();
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h200, 1'b0);
    checkOutput("s5_addr_a", memAddr, 32'h0);
    applyStimulus(1'b1, 32'h300, 1'b0);
    checkOutput("s5_addr_b", memAddr, 32'h0);
    checkOutput("s5_req", 32'(memReq), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s5_addr_c", memAddr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s5_target", memAddr, 32'h300);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("s5_no_stale", 32'(validF), 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s5_pc", pcF, 32'h300);
    checkOutput("s5_instr", instrF, 32'hC0DE_0300);

    // Address wrap on the second instance, then asynchronous reset mid-request
    resetDut();
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s6_addr_f8", memAddr2, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s6_addr_fc", memAddr2, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s6_addr_0", memAddr2, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("s6_full_req", 32'(memReq2), 32'd0);
    checkOutput("s6_head_f8", pcF2, 32'hFFFF_FFF8);
    checkOutput("s6_plus4_fc", pcPlus4F2, 32'hFFFF_FFFC);
    stall2 = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    stall2 = 1'b1;
    checkOutput("s6_head_fc", pcF2, 32'hFFFF_FFFC);
    checkOutput("s6_plus4_wrap", pcPlus4F2, 32'h0);
    checkOutput("s6_instr_fc", instrF2, 32'h3F21_FFFC);
    checkOutput("s6_pre_req", 32'(memReq), 32'd1);
    checkOutput("s6_pre_addr", memAddr, 32'h4);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("s6_async_req", 32'(memReq), 32'd0);
    checkOutput("s6_async_addr", memAddr, 32'h0);
    checkOutput("s6_async_valid", 32'(validF), 32'd0);
    checkOutput("s6_async_req2", 32'(memReq2), 32'd0);
    checkOutput("s6_async_valid2", 32'(validF2), 32'd0);
    checkOutput("s6_async_addr2", memAddr2, 32'hFFFF_FFF8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
